// File: rtl/grn_attractor_ctrl.sv
// Sweep controller for a GRN node array: per initial state, finds the s0/s1 meet point and the attractor period.
// Optional step limit on the meet search is enabled by defining GRN_TIMEOUT_EN.
module grn_attractor_ctrl #(
   parameter int NODES     = 8,
   parameter int CNT_W     = 16,
   parameter int MAX_STEPS = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             reset_nos,
   output logic [NODES-1:0] init_state,
   output logic             start_s0,
   output logic             start_s1,
   input  logic [NODES-1:0] s0_vec,
   input  logic [NODES-1:0] s1_vec,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [NODES-1:0] res_init,
   output logic [CNT_W-1:0] res_meet,
   output logic [CNT_W-1:0] res_period,
   output logic             res_timeout
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      TRANS,
      PERIOD,
      OUT
   } state_t;

`ifdef GRN_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] STEP_LIMIT = CNT_W'(MAX_STEPS);
   localparam logic [NODES-1:0] LAST_INIT  = {NODES{1'b1}};

   state_t           state;
   logic [NODES-1:0] cur_init;
   logic [CNT_W-1:0] step_cnt;
   logic [CNT_W-1:0] per_cnt;

   logic vec_eq;
   logic meet_hit;
   logic loop_hit;
   logic limit_hit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // Steps 0 and 1 coincide by construction, so the meet compare is held off until step 2.
   assign vec_eq    = (s0_vec == s1_vec);
   assign meet_hit  = (state == TRANS) && (step_cnt >= CNT_W'(2)) && vec_eq;
   assign loop_hit  = (state == PERIOD) && (per_cnt != '0) && vec_eq;
   assign limit_hit = TIMEOUT_EN && (state == TRANS) && !meet_hit && (step_cnt >= STEP_LIMIT);

   // Strobes decode the registered state and the node compare, so a step and its
   // compare land in consecutive cycles without an extra settle cycle.
   assign start_s0 = (state == TRANS) && !meet_hit && !limit_hit;
   assign start_s1 = start_s0 || ((state == PERIOD) && !loop_hit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cur_init    <= '0;
         step_cnt    <= '0;
         per_cnt     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         reset_nos   <= 1'b0;
         init_state  <= '0;
         res_valid   <= 1'b0;
         res_init    <= '0;
         res_meet    <= '0;
         res_period  <= '0;
         res_timeout <= 1'b0;
      end else begin
         // NOTE: every state register here uses <= so all of them see the pre-edge values.
         done       <= 1'b0;
         reset_nos  <= 1'b0;
         init_state <= '0;
         case (state)
            IDLE: begin
               if (start) begin
                  cur_init   <= '0;
                  busy       <= 1'b1;
                  reset_nos  <= 1'b1;
                  init_state <= '0;
                  state      <= LOAD;
               end
            end
            LOAD: begin
               step_cnt <= '0;
               per_cnt  <= '0;
               state    <= TRANS;
            end
            TRANS: begin
               if (meet_hit) begin
                  res_meet <= step_cnt;
                  state    <= PERIOD;
               end else if (limit_hit) begin
                  res_meet    <= step_cnt;
                  res_period  <= '0;
                  res_timeout <= 1'b1;
                  res_init    <= cur_init;
                  res_valid   <= 1'b1;
                  state       <= OUT;
               end else begin
                  step_cnt <= sat_inc(step_cnt);
               end
            end
            PERIOD: begin
               if (loop_hit) begin
                  res_period  <= per_cnt;
                  res_timeout <= 1'b0;
                  res_init    <= cur_init;
                  res_valid   <= 1'b1;
                  state       <= OUT;
               end else begin
                  per_cnt <= sat_inc(per_cnt);
               end
            end
            OUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (cur_init == LAST_INIT) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     cur_init   <= cur_init + NODES'(1);
                     reset_nos  <= 1'b1;
                     init_state <= cur_init + NODES'(1);
                     state      <= LOAD;
                  end
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
